// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive side of a multiplexed 7-segment display. The scanned segment pattern
//   and the one-hot digit select are registered and checked for stability. Each
//   stable glyph is decoded back to a hex nibble, and the digits are assembled
//   into a word that mirrors the value being displayed.
//
//   Build option: define SEG_ACTIVE_LOW_EN for common-anode wiring. seg_in and
//   seg_sel are then inverted ahead of the input register.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   seg_in     in   [7:0] segments, bit0=a .. bit6=g, bit7=dp
//   seg_sel    in   [NUM_DIGITS-1:0] one-hot digit select (digit 0 = LS nibble)
//   value      out  [4*NUM_DIGITS-1:0] last complete frame
//   dp_mask    out  [NUM_DIGITS-1:0] decimal points of last complete frame
//   valid      out  value/dp_mask hold a complete frame, no timeout since
//   frame_done out  one-cycle pulse in the cycle before value/dp_mask update
//   decode_err out  sticky: a stable glyph matched no hex code
//   sel_err    out  sticky: a stable non-zero select was not one-hot
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    decode_err,
  output logic                    sel_err
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {COLLECT = 1'b0, COMMIT = 1'b1} state_t;

  // Returns {hit, nibble}; hit=0 when the glyph is not a hex digit.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  logic [7:0]              seg_pin;
  logic [NUM_DIGITS-1:0]   sel_pin;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_pin = ~seg_in;
  assign sel_pin = ~seg_sel;
`else
  assign seg_pin = seg_in;
  assign sel_pin = seg_sel;
`endif

  // ---- stage p0: input register; p1: previous-cycle copy for change detect ----
  logic [7:0]              seg_p0_q, seg_p1_q;
  logic [NUM_DIGITS-1:0]   sel_p0_q, sel_p1_q;

  always_ff @(posedge clk) begin
    seg_p0_q <= seg_pin;
    sel_p0_q <= sel_pin;
    seg_p1_q <= seg_p0_q;
    sel_p1_q <= sel_p0_q;
  end

  // ---- stability qualification and capture decision ----
  logic [SW-1:0] stab_q, stab_d;
  logic          changed, capture, sel_nonzero, sel_onehot, glyph_hit, good_cap;
  logic [4:0]    dec;

  assign changed     = (seg_p0_q != seg_p1_q) || (sel_p0_q != sel_p1_q);
  assign stab_d      = changed ? '0 :
                       (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
  // Fires only on the transition into the saturated count: once per hold.
  assign capture     = (stab_d == SW'(STABLE_CYCLES)) && (stab_q != SW'(STABLE_CYCLES));
  assign sel_nonzero = |sel_p0_q;
  assign sel_onehot  = sel_nonzero && ((sel_p0_q & (sel_p0_q - NUM_DIGITS'(1))) == '0);
  assign dec         = decode_glyph(seg_p0_q[6:0]);
  assign glyph_hit   = dec[4];
  assign good_cap    = capture && sel_onehot && glyph_hit;

  // ---- frame assembly, commit and timeout ----
  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shdp_q, shdp_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    valid_q, valid_d;
  logic                    derr_q, derr_d, serr_q, serr_d;
  logic [TW-1:0]           to_q, to_d;
  logic                    timeout_hit;

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    shadow_d   = shadow_q;
    shdp_d     = shdp_q;
    value_d    = value_q;
    dp_d       = dp_q;
    valid_d    = valid_q;
    frame_done = 1'b0;
    derr_d     = derr_q | (capture && sel_onehot && !glyph_hit);
    serr_d     = serr_q | (capture && sel_nonzero && !sel_onehot);

    to_d = good_cap ? '0 :
           (to_q == TW'(TIMEOUT - 1)) ? to_q : to_q + TW'(1);
    timeout_hit = !good_cap && (to_q == TW'(TIMEOUT - 2));

    if (state_q == COMMIT) begin
      value_d    = shadow_q;
      dp_d       = shdp_q;
      valid_d    = 1'b1;
      frame_done = 1'b1;
      seen_d     = '0;
    end

    if (timeout_hit) begin
      valid_d = 1'b0;
      seen_d  = '0;
    end

    // A capture landing in the COMMIT cycle starts the next frame.
    if (good_cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_p0_q[i]) begin
          shadow_d[4*i +: 4] = dec[3:0];
          shdp_d[i]          = seg_p0_q[7];
          seen_d[i]          = 1'b1;
        end
      end
    end

    state_d = (&seen_d) ? COMMIT : COLLECT;
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    shdp_q   <= shdp_d;
    if (rst) begin
      state_q <= COLLECT;
      seen_q  <= '0;
      stab_q  <= '0;
      to_q    <= '0;
      value_q <= '0;
      dp_q    <= '0;
      valid_q <= 1'b0;
      derr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      stab_q  <= stab_d;
      to_q    <= to_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      derr_q  <= derr_d;
      serr_q  <= serr_d;
    end
  end

  assign value      = value_q;
  assign dp_mask    = dp_q;
  assign valid      = valid_q;
  assign decode_err = derr_q;
  assign sel_err    = serr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder at default parameters. Stimulus is given in
// logical (active-high) terms; under SEG_ACTIVE_LOW_EN the pins are driven inverted.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  seg_sel;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        valid, frame_done, decode_err, sel_err;

  seg_scan_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_sel    (seg_sel),
    .value      (value),
    .dp_mask    (dp_mask),
    .valid      (valid),
    .frame_done (frame_done),
    .decode_err (decode_err),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_err    = 0;
  int fd_cnt   = 0;
  int fd0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] seg, input logic [7:0] sel);
`ifdef SEG_ACTIVE_LOW_EN
    seg_in  = ~seg;
    seg_sel = ~sel;
`else
    seg_in  = seg;
    seg_sel = sel;
`endif
  endtask

  task automatic show(input int d, input logic [3:0] nib, input logic dp, input int hold);
    drive({dp, glyph[nib]}, 8'(1 << d));
    tick(hold);
  endtask

  task automatic scan(input logic [31:0] w, input logic [7:0] dpm);
    for (int d = 0; d < 8; d++) show(d, w[4*d +: 4], dpm[d], 8);
    drive(8'h00, 8'h00);
    tick(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 8'h00);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    drive(8'h00, 8'h00);

    // 1: reset state, then idle blanking
    tick(2);
    rst = 1'b0;
    chk("rst_value", value, 32'h0);
    chk("rst_dp", 32'(dp_mask), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_derr", 32'(decode_err), 32'h0);
    chk("rst_serr", 32'(sel_err), 32'h0);
    tick(100);
    chk("idle_value", value, 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_fd_cnt", 32'(fd_cnt), 32'h0);
    chk("idle_errs", {30'h0, decode_err, sel_err}, 32'h0);

    // 2: full scan of 0x1234ABCD, dp on digit 3, with exact latency on the last digit
    w   = 32'h1234ABCD;
    fd0 = fd_cnt;
    for (int d = 0; d < 7; d++) show(d, w[4*d +: 4], (d == 3), 8);
    drive({1'b0, glyph[w[31:28]]}, 8'h80);
    tick(5);
    chk("lat_early", 32'(frame_done), 32'h0);
    chk("partial_no_leak", value, 32'h0);
    tick(1);
    chk("lat_hit", 32'(frame_done), 32'h1);
    tick(2);
    drive(8'h00, 8'h00);
    tick(4);
    chk("t2_fd_count", 32'(fd_cnt - fd0), 32'h1);
    chk("t2_value", value, 32'h1234ABCD);
    chk("t2_dp", 32'(dp_mask), 32'h08);
    chk("t2_valid", 32'(valid), 32'h1);
    chk("t2_errs", {30'h0, decode_err, sel_err}, 32'h0);

    // 3: digit 4 held only 3 cycles -> never captured, no new frame
    fd0 = fd_cnt;
    for (int d = 0; d < 8; d++) show(d, w[4*d +: 4], 1'b0, (d == 4) ? 3 : 8);
    drive(8'h00, 8'h00);
    tick(10);
    chk("t3_no_fd", 32'(fd_cnt - fd0), 32'h0);
    chk("t3_value_kept", value, 32'h1234ABCD);
    chk("t3_dp_kept", 32'(dp_mask), 32'h08);
    do_reset();
    chk("t3_rst_value", value, 32'h0);
    chk("t3_rst_valid", 32'(valid), 32'h0);

    // 4: blank glyph on digit 5, then fix it; then a two-hot select
    w   = 32'h56789ABC;
    fd0 = fd_cnt;
    for (int d = 0; d < 8; d++) begin
      if (d == 5) begin
        drive(8'h00, 8'h20);
        tick(8);
      end else begin
        show(d, w[4*d +: 4], 1'b0, 8);
      end
    end
    drive(8'h00, 8'h00);
    tick(6);
    chk("t4_derr", 32'(decode_err), 32'h1);
    chk("t4_serr_clear", 32'(sel_err), 32'h0);
    chk("t4_no_fd", 32'(fd_cnt - fd0), 32'h0);
    chk("t4_valid_low", 32'(valid), 32'h0);
    show(5, w[23:20], 1'b0, 8);
    drive(8'h00, 8'h00);
    tick(4);
    chk("t4_fix_fd", 32'(fd_cnt - fd0), 32'h1);
    chk("t4_fix_value", value, 32'h56789ABC);
    chk("t4_fix_dp", 32'(dp_mask), 32'h00);
    chk("t4_fix_valid", 32'(valid), 32'h1);
    chk("t4_derr_sticky", 32'(decode_err), 32'h1);
    drive({1'b0, glyph[4'h3]}, 8'h05);
    tick(8);
    drive(8'h00, 8'h00);
    tick(2);
    chk("t4_serr", 32'(sel_err), 32'h1);
    chk("t4_sel_value", value, 32'h56789ABC);
    chk("t4_sel_no_fd", 32'(fd_cnt - fd0), 32'h1);

    // 5: timeout while blanking, value retained, rescan restores valid
    tick(4000);
    chk("t5_valid_before_to", 32'(valid), 32'h1);
    tick(200);
    chk("t5_valid_after_to", 32'(valid), 32'h0);
    chk("t5_value_kept", value, 32'h56789ABC);
    scan(32'hDEADBEEF, 8'h00);
    chk("t5_rescan_valid", 32'(valid), 32'h1);
    chk("t5_rescan_value", value, 32'hDEADBEEF);

    // 6: reset after 5 of 8 digits discards the partial frame
    w   = 32'hCAFEF00D;
    fd0 = fd_cnt;
    for (int d = 0; d < 5; d++) show(d, w[4*d +: 4], 1'b1, 8);
    do_reset();
    for (int d = 5; d < 8; d++) show(d, w[4*d +: 4], 1'b0, 8);
    drive(8'h00, 8'h00);
    tick(10);
    chk("t6_no_fd", 32'(fd_cnt - fd0), 32'h0);
    chk("t6_value", value, 32'h0);
    chk("t6_valid", 32'(valid), 32'h0);
    chk("t6_errs_cleared", {30'h0, decode_err, sel_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
